// File: rtl/multicycle_ctrl.sv
// multicycle_ctrl: multi-cycle RV32I sequencer with memory handshakes, instret counter,
// memory-wait watchdog and sticky trap state.
module multicycle_ctrl #(
    parameter int CNT_W    = 32,
    parameter int WAIT_MAX = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [6:0]       Opcode,
    input  logic [2:0]       Funct3,
    input  logic             Zero,
    input  logic             imem_ready,
    input  logic             dmem_ready,
    output logic             PCWrite,
    output logic             PCSrc,
    output logic             IRWrite,
    output logic             RegWrite,
    output logic             MemRead,
    output logic             MemWrite,
    output logic [1:0]       ALUSrcA,
    output logic [1:0]       ALUSrcB,
    output logic [3:0]       ALUOp,
    output logic [1:0]       ResultSrc,
    output logic             trap,
    output logic [CNT_W-1:0] instret
);
    localparam int WW = $clog2(WAIT_MAX + 1);
    localparam logic [WW-1:0] WLAST = WW'(WAIT_MAX - 1);
    localparam logic [6:0] OP_R = 7'b0110011, OP_I = 7'b0010011, OP_LD = 7'b0000011,
                           OP_ST = 7'b0100011, OP_BR = 7'b1100011, OP_JAL = 7'b1101111,
                           OP_JALR = 7'b1100111, OP_LUI = 7'b0110111, OP_AUIPC = 7'b0010111;

    typedef enum logic [2:0] {FETCH, DECODE, EXEC, MEM, WB, TRAP} state_t;

    state_t            state_q, state_d;
    logic [WW-1:0]     wait_q, wait_d;
    logic [CNT_W-1:0]  instret_q, instret_d;
    logic              pc_write, ir_write, reg_write, mem_read, mem_write, retire, taken;
    logic              is_r, is_i, is_ld, is_st, is_br, is_jal, is_jalr, is_lui, is_auipc, legal;

    assign is_r     = Opcode == OP_R;
    assign is_i     = Opcode == OP_I;
    assign is_ld    = Opcode == OP_LD;
    assign is_st    = Opcode == OP_ST;
    assign is_br    = Opcode == OP_BR;
    assign is_jal   = Opcode == OP_JAL;
    assign is_jalr  = Opcode == OP_JALR;
    assign is_lui   = Opcode == OP_LUI;
    assign is_auipc = Opcode == OP_AUIPC;
    assign legal    = is_r | is_i | is_ld | is_st | is_br | is_jal | is_jalr | is_lui | is_auipc;
    assign taken    = Zero ^ Funct3[0];

    always_comb begin
        state_d   = state_q;
        pc_write  = 1'b0;
        PCSrc     = 1'b0;
        ir_write  = 1'b0;
        reg_write = 1'b0;
        mem_read  = 1'b0;
        mem_write = 1'b0;
        ALUSrcA   = 2'b00;
        ALUSrcB   = 2'b00;
        ALUOp     = 4'b0000;
        ResultSrc = 2'b00;
        retire    = 1'b0;
        case (state_q)
            FETCH: begin
                ALUSrcB = 2'b10;
                if (imem_ready) begin
                    ir_write = 1'b1;
                    pc_write = 1'b1;
                    state_d  = DECODE;
                end else if (wait_q == WLAST) state_d = TRAP;
            end
            DECODE: begin
                ALUSrcA = 2'b01;
                ALUSrcB = 2'b01;
                state_d = legal ? EXEC : TRAP;
            end
            EXEC: begin
                state_d = WB;
                if (is_r) begin
                    ALUSrcA = 2'b10;
                    ALUOp   = 4'b0010;
                end else if (is_i) begin
                    ALUSrcA = 2'b10;
                    ALUSrcB = 2'b01;
                    ALUOp   = 4'b0011;
                end else if (is_lui | is_auipc) begin
                    ALUSrcA = is_lui ? 2'b11 : 2'b01;
                    ALUSrcB = 2'b01;
                end else if (is_ld | is_st) begin
                    ALUSrcA = 2'b10;
                    ALUSrcB = 2'b01;
                    state_d = MEM;
                end else if (is_br) begin
                    ALUSrcA  = 2'b10;
                    ALUOp    = 4'b0001;
                    pc_write = taken;
                    PCSrc    = taken;
                    retire   = 1'b1;
                    state_d  = FETCH;
                end else if (is_jal) begin
                    pc_write = 1'b1;
                    PCSrc    = 1'b1;
                end else if (is_jalr) begin
                    ALUSrcA  = 2'b10;
                    ALUSrcB  = 2'b01;
                    pc_write = 1'b1;
                end else state_d = TRAP;
            end
            MEM: begin
                ALUSrcA   = 2'b10;
                ALUSrcB   = 2'b01;
                mem_read  = is_ld;
                mem_write = is_st;
                if (dmem_ready) begin
                    state_d = is_ld ? WB : FETCH;
                    retire  = !is_ld;
                end else if (wait_q == WLAST) state_d = TRAP;
            end
            WB: begin
                reg_write = 1'b1;
                ResultSrc = is_ld ? 2'b01 : (is_jal | is_jalr) ? 2'b10 : 2'b00;
                ALUSrcA   = (is_jal | is_jalr) ? 2'b01 : 2'b00;
                ALUSrcB   = (is_jal | is_jalr) ? 2'b10 : 2'b00;
                retire    = 1'b1;
                state_d   = FETCH;
            end
            TRAP: state_d = TRAP;
            default: state_d = FETCH;
        endcase
        wait_d    = (state_d != state_q || state_q == TRAP) ? '0 : wait_q + 1'b1;
        instret_d = retire ? instret_q + CNT_W'(1) : instret_q;
    end

    // Enables are also gated by reset so nothing strobes while reset is held.
    assign PCWrite  = pc_write & reset;
    assign IRWrite  = ir_write & reset;
    assign RegWrite = reg_write & reset;
    assign MemRead  = mem_read & reset;
    assign MemWrite = mem_write & reset;
    assign trap     = state_q == TRAP;
    assign instret  = instret_q;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q   <= FETCH;
            wait_q    <= '0;
            instret_q <= '0;
        end else begin
            state_q   <= state_d;
            wait_q    <= wait_d;
            instret_q <= instret_d;
        end
    end
endmodule

// File: tb/tb_multicycle_ctrl.sv
// tb_multicycle_ctrl: random instruction streams checked cycle by cycle against a per-phase
// script of expected control outputs; a narrow instret exercises counter wrap.
module tb_multicycle_ctrl;
    localparam int CW = 4, WM = 16;
    localparam int R = 0, I = 1, LD = 2, ST = 3, BR = 4, JAL = 5, JALR = 6, LUI = 7, AUIPC = 8, ILL = 9;

    logic clk = 1'b0, reset = 1'b0;
    logic [6:0] Opcode = '0;
    logic [2:0] Funct3 = '0;
    logic Zero = 1'b0, imem_ready = 1'b0, dmem_ready = 1'b0;
    logic PCWrite, PCSrc, IRWrite, RegWrite, MemRead, MemWrite, trap;
    logic [1:0] ALUSrcA, ALUSrcB, ResultSrc;
    logic [3:0] ALUOp;
    logic [CW-1:0] instret;
    logic [16:0] outs;
    logic [CW-1:0] m_instret = '0;
    int n_chk = 0, n_fail = 0;

    always #5 clk = ~clk;

    multicycle_ctrl #(.CNT_W(CW), .WAIT_MAX(WM)) dut (
        .clk(clk), .reset(reset), .Opcode(Opcode), .Funct3(Funct3), .Zero(Zero),
        .imem_ready(imem_ready), .dmem_ready(dmem_ready), .PCWrite(PCWrite), .PCSrc(PCSrc),
        .IRWrite(IRWrite), .RegWrite(RegWrite), .MemRead(MemRead), .MemWrite(MemWrite),
        .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB), .ALUOp(ALUOp), .ResultSrc(ResultSrc),
        .trap(trap), .instret(instret)
    );

    assign outs = {PCWrite, PCSrc, IRWrite, RegWrite, MemRead, MemWrite, ALUSrcA, ALUSrcB, ALUOp, ResultSrc, trap};

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic logic [16:0] o(input logic pcw, pcs, irw, rw, mr, mw,
                                      input logic [1:0] a, b, input logic [3:0] op,
                                      input logic [1:0] rs, input logic tr);
        return {pcw, pcs, irw, rw, mr, mw, a, b, op, rs, tr};
    endfunction

    function automatic logic [6:0] opc(input int t);
        case (t)
            R: return 7'b0110011;      I: return 7'b0010011;    LD: return 7'b0000011;
            ST: return 7'b0100011;     BR: return 7'b1100011;   JAL: return 7'b1101111;
            JALR: return 7'b1100111;   LUI: return 7'b0110111;  AUIPC: return 7'b0010111;
            default: return 7'b1111111;
        endcase
    endfunction

    task automatic cyc(input string tag, input logic [16:0] e);
        @(negedge clk);
        check(tag, 32'(outs), 32'(e));
        @(posedge clk);
        #1;
    endtask

    task automatic retired();
        m_instret++;
        check("instret", 32'(instret), 32'(m_instret));
    endtask

    task automatic async_reset(input string tag);
        reset = 1'b0;
        imem_ready = 1'b0;
        dmem_ready = 1'b0;
        #1;
        check({tag, "_outs"}, 32'(outs), 32'(o(0, 0, 0, 0, 0, 0, 0, 2, 0, 0, 0)));
        check({tag, "_instret"}, 32'(instret), 0);
        m_instret = '0;
        @(posedge clk);
        #1;
        reset = 1'b1;
    endtask

    task automatic trap_out();
        repeat (3) cyc("trap", o(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1));
        check("instret_frozen", 32'(instret), 32'(m_instret));
        async_reset("trap_rst");
    endtask

    task automatic run(input int t, input int imw, input int dmw, input logic z,
                       input logic [2:0] f3, input int rst_mem);
        logic [6:0] op;
        logic tk;
        bit done;
        logic [16:0] e;
        op = opc(t);
        if (t == ILL) begin
            op = 7'($urandom);
            while (op == 7'b0110011 || op == 7'b0010011 || op == 7'b0000011 || op == 7'b0100011 ||
                   op == 7'b1100011 || op == 7'b1101111 || op == 7'b1100111 || op == 7'b0110111 ||
                   op == 7'b0010111) op = 7'($urandom);
        end
        Opcode = op;
        Funct3 = f3;
        Zero = z;
        dmem_ready = 1'b0;
        done = 0;
        for (int c = 0; c < WM; c++) begin
            imem_ready = (c >= imw);
            if (imem_ready) begin
                cyc("fetch", o(1, 0, 1, 0, 0, 0, 0, 2, 0, 0, 0));
                done = 1;
                break;
            end
            cyc("fetch_wait", o(0, 0, 0, 0, 0, 0, 0, 2, 0, 0, 0));
        end
        imem_ready = 1'($urandom);
        if (!done) begin
            trap_out();
            return;
        end
        dmem_ready = 1'($urandom);
        cyc("decode", o(0, 0, 0, 0, 0, 0, 1, 1, 0, 0, 0));
        if (t == ILL) begin
            trap_out();
            return;
        end
        tk = z ^ f3[0];
        case (t)
            R:      e = o(0, 0, 0, 0, 0, 0, 2, 0, 2, 0, 0);
            I:      e = o(0, 0, 0, 0, 0, 0, 2, 1, 3, 0, 0);
            LUI:    e = o(0, 0, 0, 0, 0, 0, 3, 1, 0, 0, 0);
            AUIPC:  e = o(0, 0, 0, 0, 0, 0, 1, 1, 0, 0, 0);
            BR:     e = o(tk, tk, 0, 0, 0, 0, 2, 0, 1, 0, 0);
            JAL:    e = o(1, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0);
            JALR:   e = o(1, 0, 0, 0, 0, 0, 2, 1, 0, 0, 0);
            default: e = o(0, 0, 0, 0, 0, 0, 2, 1, 0, 0, 0);
        endcase
        dmem_ready = 1'b0;
        cyc("exec", e);
        if (t == BR) begin
            retired();
            return;
        end
        if (t == LD || t == ST) begin
            done = 0;
            e = o(0, 0, 0, 0, t == LD, t == ST, 2, 1, 0, 0, 0);
            for (int c = 0; c < WM; c++) begin
                dmem_ready = (c >= dmw);
                if (c == rst_mem) begin
                    @(negedge clk);
                    check("mem_pre_rst", 32'(outs), 32'(e));
                    #1;
                    async_reset("mem_rst");
                    return;
                end
                cyc("mem", e);
                if (dmem_ready) begin
                    done = 1;
                    break;
                end
            end
            dmem_ready = 1'b0;
            if (!done) begin
                trap_out();
                return;
            end
            if (t == ST) begin
                retired();
                return;
            end
        end
        if (t == LD) e = o(0, 0, 0, 1, 0, 0, 0, 0, 0, 1, 0);
        else if (t == JAL || t == JALR) e = o(0, 0, 0, 1, 0, 0, 1, 2, 0, 2, 0);
        else e = o(0, 0, 0, 1, 0, 0, 0, 0, 0, 0, 0);
        cyc("wb", e);
        retired();
    endtask

    function automatic int pick_wait();
        int r;
        r = $urandom_range(0, 39);
        return r == 0 ? WM : r == 1 ? WM - 1 : $urandom_range(0, 3);
    endfunction

    initial begin
        imem_ready = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        check("rst_outs", 32'(outs), 32'(o(0, 0, 0, 0, 0, 0, 0, 2, 0, 0, 0)));
        check("rst_instret", 32'(instret), 0);
        reset = 1'b1;
        imem_ready = 1'b0;
        run(I, 0, 0, 0, 3'b000, -1);
        run(BR, 0, 0, 1, 3'b000, -1);
        run(BR, 0, 0, 1, 3'b001, -1);
        run(LD, 0, 3, 0, 3'b010, -1);
        run(JAL, 0, 0, 0, 3'b000, -1);
        run(JALR, 0, 0, 0, 3'b000, -1);
        run(ST, 0, WM - 1, 0, 3'b010, -1);
        run(R, WM - 1, 0, 0, 3'b000, -1);
        run(ST, 0, WM, 0, 3'b010, -1);
        run(ILL, 0, 0, 0, 3'b000, -1);
        run(ST, 1, WM, 0, 3'b010, 3);
        run(I, WM, 0, 0, 3'b000, -1);
        for (int k = 0; k < 300; k++) begin
            int r, t;
            r = $urandom_range(0, 99);
            t = r < 3 ? ILL : r % 9;
            run(t, pick_wait(), pick_wait(), 1'($urandom), 3'($urandom),
                $urandom_range(0, 29) == 0 ? $urandom_range(0, 2) : -1);
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
